// File: rtl/core_pkg.sv
// core_pkg: shared divider-writeback state encoding and default widths.
package core_pkg;
    localparam int DWB_REG_AW = 5;
    localparam int DWB_XLEN   = 32;
    typedef enum logic [1:0] {
        DWB_IDLE = 2'd0,
        DWB_BUSY = 2'd1,
        DWB_PEND = 2'd2
    } dwb_state_e;
endpackage

// File: rtl/div_writeback_ctrl.sv
// div_writeback_ctrl: launches divides, tracks the in-flight rd for hazards,
// and merges the divider result into the shared register-file write port.
module div_writeback_ctrl
    import core_pkg::*;
#(
    parameter int REG_AW = DWB_REG_AW,
    parameter int XLEN   = DWB_XLEN
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              issue_valid_i,
    input  logic              issue_div_i,
    input  logic [REG_AW-1:0] issue_rd_i,
    input  logic [REG_AW-1:0] issue_rs1_i,
    input  logic [REG_AW-1:0] issue_rs2_i,
    input  logic              flush_i,
    output logic              div_start_o,
    input  logic              div_valid_i,
    input  logic [XLEN-1:0]   div_value_i,
    input  logic              pipe_wb_valid_i,
    input  logic [REG_AW-1:0] pipe_wb_rd_i,
    input  logic [XLEN-1:0]   pipe_wb_value_i,
    output logic              rf_we_o,
    output logic [REG_AW-1:0] rf_waddr_o,
    output logic [XLEN-1:0]   rf_wdata_o,
    output logic              stall_o
);
    dwb_state_e        state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              kill_q, kill_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              launch, pend_wr, tracking, hazard;

    assign launch   = issue_valid_i & issue_div_i & ~flush_i;
    assign pend_wr  = (state_q == DWB_PEND) & ~flush_i & ~pipe_wb_valid_i;
    assign tracking = (state_q == DWB_BUSY) | (state_q == DWB_PEND);
    assign hazard   = (rd_q != '0) & ((rd_q == issue_rs1_i) | (rd_q == issue_rs2_i) | (rd_q == issue_rd_i));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= DWB_IDLE;
            rd_q    <= '0;
            kill_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            kill_q  <= kill_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        kill_d  = kill_q;
        res_d   = res_q;
        case (state_q)
            DWB_IDLE: if (launch) begin
                state_d = DWB_BUSY;
                rd_d    = issue_rd_i;
                kill_d  = 1'b0;
            end
            DWB_BUSY: if (div_valid_i) begin
                res_d   = div_value_i;
                state_d = (kill_q | flush_i | rd_q == '0) ? DWB_IDLE : DWB_PEND;
            end else if (flush_i) begin
                kill_d = 1'b1;
            end
            DWB_PEND: state_d = (flush_i | ~pipe_wb_valid_i) ? DWB_IDLE : DWB_PEND;
            default:  state_d = DWB_IDLE;
        endcase
    end

    // Main-pipeline writeback always owns the port; the buffered result waits.
    always_comb begin
        div_start_o = (state_q == DWB_IDLE) & launch;
        stall_o     = issue_valid_i & ~flush_i & tracking & (issue_div_i | hazard);
        rf_we_o     = pipe_wb_valid_i | pend_wr;
        rf_waddr_o  = pipe_wb_valid_i ? pipe_wb_rd_i : pend_wr ? rd_q : '0;
        rf_wdata_o  = pipe_wb_valid_i ? pipe_wb_value_i : pend_wr ? res_q : '0;
    end
endmodule

// File: tb/tb_div_writeback_ctrl.sv
// tb_div_writeback_ctrl: randomized scoreboard bench with a divider stub and
// a flag-based reference model of the divide lifecycle.
module tb_div_writeback_ctrl;
    logic        clk = 0, rstn = 0;
    logic        iv = 0, idiv = 0, fl = 0, dv = 0, pwv = 0;
    logic [4:0]  ird = 0, irs1 = 0, irs2 = 0, pwrd = 0;
    logic [31:0] dval = 0, pwval = 0;
    logic        start, we, stall;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int checks = 0, errors = 0;
    logic [36:0] wq[$];

    bit          m_busy = 0, m_kill = 0, m_have = 0;
    logic [4:0]  m_rd = 0;
    logic [31:0] m_res = 0;
    int          cnt = 0, fixed_lat = 0;
    logic [31:0] fixed_val = 0;
    bit          e_start, e_stall;

    always #5 clk = ~clk;

    div_writeback_ctrl dut (
        .clk_i(clk), .rstn_i(rstn),
        .issue_valid_i(iv), .issue_div_i(idiv),
        .issue_rd_i(ird), .issue_rs1_i(irs1), .issue_rs2_i(irs2),
        .flush_i(fl), .div_start_o(start),
        .div_valid_i(dv), .div_value_i(dval),
        .pipe_wb_valid_i(pwv), .pipe_wb_rd_i(pwrd), .pipe_wb_value_i(pwval),
        .rf_we_o(we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
        .stall_o(stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (rstn) begin
        if (we) begin
            if (wq.size() == 0) chk("unexpected_write", {27'd0, waddr, wdata}, 64'd0);
            else chk("write", {27'd0, waddr, wdata}, {27'd0, wq.pop_front()});
        end else begin
            chk("idle_port", {27'd0, waddr, wdata}, 64'd0);
        end
    end

    task automatic step(input bit v, input bit d, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input bit f, input bit p);
        iv = v; idiv = d; ird = rd; irs1 = r1; irs2 = r2; fl = f; pwv = p;
        pwrd = 5'($urandom); pwval = $urandom;
        dv = 0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                dv = 1;
                dval = fixed_lat != 0 ? fixed_val : $urandom;
            end
        end
        if (dv && !m_busy) $error("divider pulse outside an in-flight divide");
        e_start = !m_busy && !m_have && v && d && !f;
        e_stall = v && !f && (m_busy || m_have) &&
                  (d || (m_rd != 0 && (m_rd == r1 || m_rd == r2 || m_rd == rd)));
        if (p) wq.push_back({pwrd, pwval});
        else if (m_have && !f) wq.push_back({m_rd, m_res});
        @(negedge clk);
        chk("div_start", {63'd0, start}, {63'd0, e_start});
        chk("stall", {63'd0, stall}, {63'd0, e_stall});
        @(posedge clk);
        if (e_start) begin
            m_busy = 1; m_kill = 0; m_rd = rd;
            cnt = fixed_lat != 0 ? fixed_lat : int'($urandom_range(1, 5));
        end else if (m_busy) begin
            if (dv) begin
                m_busy = 0; m_res = dval;
                m_have = !(m_kill || f || m_rd == 0);
            end else if (f) m_kill = 1;
        end else if (m_have && (f || !p)) m_have = 0;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_start", {63'd0, start}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_port", {26'd0, we, waddr, wdata}, 64'd0);
        rstn = 1;
        @(posedge clk); #1;
        fixed_lat = 4; fixed_val = 32'd14;
        step(1, 1, 5, 0, 0, 0, 0);
        repeat (6) step(1, 0, 6, 5, 0, 0, 0);
        fixed_lat = 2; fixed_val = 32'hCAFE_0001;
        step(1, 1, 9, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);
        fixed_lat = 5; fixed_val = 32'hDEAD_0002;
        step(1, 1, 7, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 7, 0, 1, 0);
        repeat (5) step(0, 0, 0, 0, 0, 0, 0);
        fixed_lat = 3; fixed_val = 32'h1234_5678;
        step(1, 1, 0, 0, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0, 0, 0);
        fixed_lat = 2; fixed_val = 32'h0BAD_F00D;
        step(1, 1, 3, 0, 0, 0, 0);
        repeat (8) step(1, 1, 4, 1, 2, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0);
        fixed_lat = 0;
        repeat (3000) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3);
        end
        repeat (8) step(0, 0, 0, 0, 0, 0, 0);
        chk("queue_drained", 64'(wq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
